mem_responder: RTL and testbench

- Memory-side responder for the multicycle controller's memory request interface (mem_read / mem_write / address / write data).
- Accepts one request at a time and models a fixed, parameterised access latency. Returns read data with a one-cycle ready pulse.
- Flags illegal requests with an error pulse.
- Sits between the controller/datapath and the word-addressed instruction/data RAM. The controller's FSM stalls in its memory state until ready is asserted.

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Memory request/response bus between the multicycle controller and the RAM responder.
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with a fixed access latency, one-cycle ready
// pulse and an error pulse for conflicting or out-of-range requests.
//
//   state  | meaning
//   S_IDLE | waiting for mem_read/mem_write; request latched on acceptance
//   S_WAIT | latency countdown; access performed on the edge where cnt==0
//   S_RESP | ready (and err if illegal) high for this single cycle
module mem_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_LD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_rd;
  logic              lat_wr;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;

  // Array is deliberately not reset so it maps onto plain RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              addr_ok;
  logic              illegal;
  logic              access;
  logic [IDX_W-1:0]  idx;

  assign addr_ok = ({1'b0, lat_addr} < DEPTH_L);
  assign illegal = (lat_rd & lat_wr) | ~addr_ok;
  assign access  = (state == S_WAIT) && (cnt == 4'd0);
  // Only used when addr_ok, so truncation never aliases a legal access.
  assign idx     = lat_addr[IDX_W-1:0];

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

  // Request sequencing, latency countdown and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (bus.mem_read || bus.mem_write) begin
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            lat_rd    <= bus.mem_read;
            lat_wr    <= bus.mem_write;
            cnt       <= CNT_LD;
            busy_q    <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= S_RESP;
            ready_q <= 1'b1;
            err_q   <= illegal;
            // Out-of-range reads return zero; conflicting requests leave rdata alone.
            if (lat_rd && !lat_wr) begin
              rdata_q <= addr_ok ? mem[idx] : '0;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // RAM write port; fires only for a legal write on the access edge.
  always_ff @(posedge clk) begin
    if (access && lat_wr && !lat_rd && addr_ok) begin
      mem[idx] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus a randomized
// phase, all compared against a transaction-level model of the RAM.
module tb_mem_responder;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 256;
  localparam int LAT    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_responder #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] model_rdata;
  logic [ADDR_W-1:0] pool [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request, dropped right after acceptance; the bus inputs are then
  // scrambled to show that only the latched values matter.
  task automatic do_txn(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input string tag);
    int   cyc;
    logic exp_err;
    exp_err = (rd && wr) || (a >= DEPTH);
    @(negedge clk);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = d;
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = a + 12'd1;
    bus.wdata     = ~d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, "_busy_first"}, bus.busy, 1);
    end while (!bus.ready && cyc < 40);
    if (rd && !wr) model_rdata = (a < DEPTH) ? model_mem[a[7:0]] : '0;
    if (wr && !rd && a < DEPTH) model_mem[a[7:0]] = d;
    chk({tag, "_latency"}, cyc, LAT + 1);
    chk({tag, "_ready"}, bus.ready, 1);
    chk({tag, "_err"}, bus.err, exp_err);
    chk({tag, "_rdata"}, bus.rdata, model_rdata);
    chk({tag, "_busy_resp"}, bus.busy, 1);
    @(negedge clk);
    chk({tag, "_ready_drop"}, bus.ready, 0);
    chk({tag, "_err_drop"}, bus.err, 0);
    chk({tag, "_busy_drop"}, bus.busy, 0);
    chk({tag, "_rdata_hold"}, bus.rdata, model_rdata);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    int p0;
    int p1;
    int cyc;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    model_rdata   = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;

    // Reset and idle behaviour.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready", bus.ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rdata", bus.rdata, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ready || bus.busy) pulses++;
    end
    chk("idle_quiet", pulses, 0);

    // Write then read back.
    do_txn(1'b0, 1'b1, 12'h010, 16'hBEEF, "wr_010");
    do_txn(1'b1, 1'b0, 12'h010, 16'h0000, "rd_010");

    // Request held across RESP produces back-to-back accesses.
    do_txn(1'b0, 1'b1, 12'h005, 16'h5A5A, "wr_005");
    @(negedge clk);
    bus.mem_read = 1'b1;
    bus.addr     = 12'h005;
    pulses = 0;
    p0 = -1;
    p1 = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        if (pulses == 0) p0 = i;
        else p1 = i;
        pulses++;
        chk("held_rdata", bus.rdata, model_mem[5]);
      end
    end
    bus.mem_read = 1'b0;
    chk("held_pulses", pulses, 2);
    chk("held_spacing", p1 - p0, LAT + 2);
    model_rdata = model_mem[5];
    cyc = 0;
    while (bus.busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_settle", bus.busy, 0);

    // Inputs changed during WAIT are ignored (do_txn moves addr to 0x021).
    do_txn(1'b0, 1'b1, 12'h021, 16'h7777, "wr_021");
    do_txn(1'b0, 1'b1, 12'h020, 16'h1234, "wr_020");
    do_txn(1'b1, 1'b0, 12'h020, 16'h0000, "rd_020");
    do_txn(1'b1, 1'b0, 12'h021, 16'h0000, "rd_021");

    // Illegal requests.
    do_txn(1'b1, 1'b1, 12'h010, 16'hDEAD, "both_010");
    do_txn(1'b1, 1'b0, 12'h010, 16'h0000, "rd_010_after_both");
    do_txn(1'b0, 1'b1, 12'h000, 16'h1111, "wr_000");
    do_txn(1'b1, 1'b0, 12'h100, 16'h0000, "rd_oob");
    do_txn(1'b0, 1'b1, 12'h100, 16'hCAFE, "wr_oob");
    do_txn(1'b1, 1'b0, 12'h000, 16'h0000, "rd_000_after_oob");

    // Reset in the first WAIT cycle aborts the write.
    do_txn(1'b0, 1'b1, 12'h030, 16'h5555, "wr_030");
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.addr      = 12'h030;
    bus.wdata     = 16'hAAAA;
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    chk("abort_busy_before", bus.busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_ready", bus.ready, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_err", bus.err, 0);
    chk("abort_rdata", bus.rdata, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.ready) pulses++;
    end
    rst = 1'b1;
    model_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.ready) pulses++;
    end
    chk("abort_no_ready", pulses, 0);
    do_txn(1'b1, 1'b0, 12'h030, 16'h0000, "rd_030_after_abort");

    // Randomized traffic over a pool of known addresses plus illegal requests.
    for (int i = 0; i < 16; i++) begin
      pool[i] = 12'(64 + i * 12 + $urandom_range(0, 10));
      do_txn(1'b0, 1'b1, pool[i], 16'($urandom), "rnd_init");
    end
    for (int i = 0; i < 60; i++) begin
      int sel;
      logic [ADDR_W-1:0] a;
      sel = $urandom_range(0, 11);
      a   = pool[$urandom_range(0, 15)];
      if (sel <= 5)       do_txn(1'b1, 1'b0, a, 16'($urandom), "rnd_rd");
      else if (sel <= 8)  do_txn(1'b0, 1'b1, a, 16'($urandom), "rnd_wr");
      else if (sel == 9)  do_txn(1'b1, 1'b1, a, 16'($urandom), "rnd_both");
      else if (sel == 10) do_txn(1'b1, 1'b0, 12'($urandom_range(DEPTH, 4095)), 16'($urandom), "rnd_rd_oob");
      else                do_txn(1'b0, 1'b1, 12'($urandom_range(DEPTH, 4095)), 16'($urandom), "rnd_wr_oob");
    end
    for (int i = 0; i < 16; i++) begin
      do_txn(1'b1, 1'b0, pool[i], 16'h0000, "rnd_final");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
